// File: rtl/fifo_bank_pkg.sv
// rtl/fifo_bank_pkg.sv - shared state enum and default bank geometry for the FIFO bank sequencer
package fifo_bank_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Shared with the FIFO instances so the bank and the sequencer agree on geometry
  localparam int DEF_NUM_FIFO   = 8;
  localparam int DEF_DEPTH      = 8;
  localparam int DEF_DATA_WIDTH = 8;

endpackage

// File: rtl/onehot_dec.sv
// rtl/onehot_dec.sv - gated binary-to-one-hot decoder driving the per-FIFO write strobes
module onehot_dec #(
  parameter int N     = 2,
  parameter int SEL_W = 1
) (
  input  logic [SEL_W-1:0] sel,
  input  logic             en,
  output logic [N-1:0]     onehot
);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < N; i++) begin
      onehot[i] = en && (sel == SEL_W'(i));
    end
  end

endmodule

// File: rtl/fifo_bank_seq.sv
// rtl/fifo_bank_seq.sv - fills a bank of FIFOs one after another, then drains them in lockstep
module fifo_bank_seq
  import fifo_bank_pkg::*;
#(
  parameter int NUM_FIFO   = DEF_NUM_FIFO,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic [NUM_FIFO-1:0]   fifo_wren,
  output logic [DATA_WIDTH-1:0] fifo_wdata,
  output logic                  fifo_rden,
  input  logic [NUM_FIFO-1:0]   fifo_full,
  input  logic [NUM_FIFO-1:0]   fifo_empty,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SEL_W = $clog2(NUM_FIFO);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_FIFO - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] wr_cnt, rd_cnt;
  logic [SEL_W-1:0] sel;
  logic             wr_accept;
  logic             fill_blocked;
  logic             any_empty;
  logic             last_wr;
  logic             last_rd;

  assign any_empty = |fifo_empty;
  assign last_wr   = (wr_cnt == LAST_IDX);
  assign last_rd   = (rd_cnt == LAST_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    in_ready     = 1'b0;
    fifo_wdata   = '0;
    fifo_rden    = 1'b0;
    wr_accept    = 1'b0;
    fill_blocked = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_FILL;
        end
      end
      ST_FILL: begin
        in_ready     = !fifo_full[sel];
        fill_blocked = fifo_full[sel] && (wr_cnt < DEPTH_C);
        wr_accept    = in_valid && in_ready;
        fifo_wdata   = in_data;
        if (wr_accept && last_wr && (sel == LAST_SEL)) begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // A read only happens when every FIFO can supply an entry, so the beat stays aligned
        fifo_rden = out_ready && !any_empty;
        if (fifo_rden && last_rd) begin
          state_nxt = ST_DONE;
        end else if (any_empty && (rd_cnt < DEPTH_C)) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
      sel    <= '0;
      err    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            wr_cnt <= '0;
            rd_cnt <= '0;
            sel    <= '0;
            err    <= 1'b0;
          end
        end
        ST_FILL: begin
          if (fill_blocked) begin
            err <= 1'b1;
          end
          if (wr_accept) begin
            if (last_wr) begin
              wr_cnt <= '0;
              // sel parks on the last FIFO instead of wrapping when the fill completes
              if (sel != LAST_SEL) begin
                sel <= sel + SEL_W'(1);
              end
            end else begin
              wr_cnt <= wr_cnt + CNT_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (fifo_rden) begin
            rd_cnt <= rd_cnt + CNT_W'(1);
          end
          if (any_empty && (rd_cnt < DEPTH_C)) begin
            err <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  onehot_dec #(
    .N    (NUM_FIFO),
    .SEL_W(SEL_W)
  ) u_wren_dec (
    .sel   (sel),
    .en    (wr_accept),
    .onehot(fifo_wren)
  );

  assign out_valid = fifo_rden;
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);

endmodule

// File: tb/tb_fifo_bank_seq.sv
// tb/tb_fifo_bank_seq.sv - directed bench for fifo_bank_seq with a two-FIFO bank model attached
module tb_fifo_bank_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       out_ready = 1'b0;
  logic       in_ready;
  logic [1:0] fifo_wren;
  logic [7:0] fifo_wdata;
  logic       fifo_rden;
  logic [1:0] fifo_full;
  logic [1:0] fifo_empty;
  logic       out_valid;
  logic       busy;
  logic       done;
  logic       err;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  fifo_bank_seq #(
    .NUM_FIFO  (2),
    .DEPTH     (4),
    .DATA_WIDTH(8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .fifo_wren (fifo_wren),
    .fifo_wdata(fifo_wdata),
    .fifo_rden (fifo_rden),
    .fifo_full (fifo_full),
    .fifo_empty(fifo_empty),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  // Two 4-deep shift-register FIFOs; read data is the head entry, valid under rden
  logic [7:0] fmem [2][4];
  int         fcnt [2];
  logic       force_e1 = 1'b0;
  logic [7:0] rd0, rd1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      fcnt[0] <= 0;
      fcnt[1] <= 0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (fifo_wren[i] && fcnt[i] < 4) begin
          fmem[i][fcnt[i]] <= fifo_wdata;
          fcnt[i] <= fcnt[i] + 1;
        end else if (fifo_rden && fcnt[i] > 0) begin
          for (int k = 0; k < 3; k++) fmem[i][k] <= fmem[i][k+1];
          fcnt[i] <= fcnt[i] - 1;
        end
      end
    end
  end

  assign fifo_full  = {fcnt[1] == 4, fcnt[0] == 4};
  assign fifo_empty = {(fcnt[1] == 0) || force_e1, fcnt[0] == 0};
  assign rd0 = fmem[0][0];
  assign rd1 = fmem[1][0];

  int          cyc = 0;
  int          start_cyc = 0;
  int          done_cyc = 0;
  int          done_cnt = 0;
  bit          err_seen = 0;
  bit          in_stall = 0;
  bit          rden_in_stall = 0;
  bit          ov_bad = 0;
  logic [9:0]  wlog [$];
  logic [15:0] rlog [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (|fifo_wren) wlog.push_back({fifo_wren, fifo_wdata});
      if (fifo_rden) rlog.push_back({rd1, rd0});
      if (fifo_rden && in_stall) rden_in_stall = 1;
      if (out_valid !== fifo_rden) ov_bad = 1;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (start && !busy) start_cyc = cyc;
      if (err) err_seen = 1;
    end
  end

  task automatic run_job(input bit gap, input int stall_at, input int stall_len,
                         input int abort_after, input bit busy_start, input int nbeats);
    int idx;
    int reads;
    int tmo;
    int stall_left;
    bit stalled;
    wlog.delete();
    rlog.delete();
    done_cnt = 0;
    err_seen = 0;
    rden_in_stall = 0;
    ov_bad = 0;
    stalled = 0;
    @(posedge clk); #1;
    start = 1; in_valid = 0; out_ready = 1;
    @(posedge clk); #1;
    start = 0;
    idx = 0;
    tmo = 0;
    while (idx < nbeats && tmo < 200) begin
      in_valid = gap ? (tmo % 2 == 0) : 1'b1;
      in_data  = 8'(idx + 1);
      start    = busy_start && (idx == 2);
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      @(posedge clk); #1;
      tmo++;
    end
    in_valid = 0;
    start = 0;
    if (nbeats < 8) return;
    reads = 0;
    tmo = 0;
    stall_left = 0;
    while (done_cnt == 0 && tmo < 200) begin
      if (reads == stall_at && !stalled) begin
        stall_left = stall_len;
        stalled = 1;
      end
      out_ready = (stall_left == 0);
      in_stall  = (stall_left > 0);
      force_e1  = (abort_after >= 0) && (reads >= abort_after);
      start     = busy_start && (reads == 4);
      @(negedge clk);
      if (fifo_rden) reads++;
      if (stall_left > 0) stall_left--;
      @(posedge clk); #1;
      tmo++;
    end
    start = 0;
    out_ready = 1;
    in_stall = 0;
    force_e1 = 0;
  endtask

  task automatic test_reset();
    in_valid = 1;
    in_data = 8'hA5;
    out_ready = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    total++; if (fifo_wren !== 2'b00) begin bad++; $display("FAIL reset_wren got=%b exp=00", fifo_wren); end
    total++; if (fifo_rden !== 1'b0) begin bad++; $display("FAIL reset_rden got=%b exp=0", fifo_rden); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (fifo_wdata !== 8'h00) begin bad++; $display("FAIL reset_wdata got=%h exp=00", fifo_wdata); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
    @(posedge clk); #1;
    rst = 0;
    in_valid = 0;
  endtask

  task automatic test_basic();
    logic [9:0]  ew;
    logic [15:0] er;
    run_job(0, -1, 0, -1, 0, 8);
    total++; if (wlog.size() !== 8) begin bad++; $display("FAIL basic_wr_count got=%0d exp=8", wlog.size()); end
    for (int i = 0; i < 8; i++) begin
      ew = {(i < 4) ? 2'b01 : 2'b10, 8'(i + 1)};
      total++;
      if (i >= wlog.size() || wlog[i] !== ew) begin
        bad++; $display("FAIL basic_wr[%0d] got=%h exp=%h", i, (i < wlog.size()) ? wlog[i] : 10'h0, ew);
      end
    end
    for (int i = 0; i < 4; i++) begin
      er = {8'(i + 5), 8'(i + 1)};
      total++;
      if (i >= rlog.size() || rlog[i] !== er) begin
        bad++; $display("FAIL basic_rd[%0d] got=%h exp=%h", i, (i < rlog.size()) ? rlog[i] : 16'h0, er);
      end
    end
    total++; if (rlog.size() !== 4) begin bad++; $display("FAIL basic_rd_count got=%0d exp=4", rlog.size()); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL basic_done_count got=%0d exp=1", done_cnt); end
    total++; if (done_cyc - start_cyc !== 13) begin bad++; $display("FAIL basic_latency got=%0d exp=13", done_cyc - start_cyc); end
    total++; if (err_seen !== 1'b0) begin bad++; $display("FAIL basic_err got=%b exp=0", err_seen); end
    total++; if (ov_bad !== 1'b0) begin bad++; $display("FAIL basic_out_valid_vs_rden got=%b exp=0", ov_bad); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_after got=%b exp=0", busy); end
  endtask

  task automatic test_gaps();
    run_job(1, -1, 0, -1, 0, 8);
    total++; if (wlog.size() !== 8) begin bad++; $display("FAIL gaps_wr_count got=%0d exp=8", wlog.size()); end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (i >= wlog.size() || wlog[i][7:0] !== 8'(i + 1)) begin
        bad++; $display("FAIL gaps_wr[%0d] got=%h exp=%h", i, (i < wlog.size()) ? wlog[i] : 10'h0, 8'(i + 1));
      end
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (i >= rlog.size() || rlog[i] !== {8'(i + 5), 8'(i + 1)}) begin
        bad++; $display("FAIL gaps_rd[%0d] got=%h exp=%h", i, (i < rlog.size()) ? rlog[i] : 16'h0, {8'(i + 5), 8'(i + 1)});
      end
    end
    total++; if (err_seen !== 1'b0) begin bad++; $display("FAIL gaps_err got=%b exp=0", err_seen); end
    total++; if (done_cyc - start_cyc !== 20) begin bad++; $display("FAIL gaps_latency got=%0d exp=20", done_cyc - start_cyc); end
  endtask

  task automatic test_backpressure();
    run_job(0, 2, 5, -1, 0, 8);
    total++; if (rden_in_stall !== 1'b0) begin bad++; $display("FAIL bp_rden_in_stall got=%b exp=0", rden_in_stall); end
    total++; if (rlog.size() !== 4) begin bad++; $display("FAIL bp_rd_count got=%0d exp=4", rlog.size()); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (i >= rlog.size() || rlog[i] !== {8'(i + 5), 8'(i + 1)}) begin
        bad++; $display("FAIL bp_rd[%0d] got=%h exp=%h", i, (i < rlog.size()) ? rlog[i] : 16'h0, {8'(i + 5), 8'(i + 1)});
      end
    end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL bp_done_count got=%0d exp=1", done_cnt); end
    total++; if (done_cyc - start_cyc !== 18) begin bad++; $display("FAIL bp_latency got=%0d exp=18", done_cyc - start_cyc); end
    total++; if (err_seen !== 1'b0) begin bad++; $display("FAIL bp_err got=%b exp=0", err_seen); end
  endtask

  task automatic test_start_busy();
    run_job(0, -1, 0, -1, 1, 8);
    for (int i = 0; i < 8; i++) begin
      total++;
      if (i >= wlog.size() || wlog[i] !== {(i < 4) ? 2'b01 : 2'b10, 8'(i + 1)}) begin
        bad++; $display("FAIL sb_wr[%0d] got=%h exp=%h", i, (i < wlog.size()) ? wlog[i] : 10'h0, {(i < 4) ? 2'b01 : 2'b10, 8'(i + 1)});
      end
    end
    total++; if (rlog.size() !== 4) begin bad++; $display("FAIL sb_rd_count got=%0d exp=4", rlog.size()); end
    total++; if (done_cyc - start_cyc !== 13) begin bad++; $display("FAIL sb_latency got=%0d exp=13", done_cyc - start_cyc); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL sb_busy_after got=%b exp=0", busy); end
    repeat (3) @(posedge clk);
    #1;
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL sb_done_count got=%0d exp=1", done_cnt); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL sb_busy_idle got=%b exp=0", busy); end
  endtask

  task automatic test_empty_abort();
    run_job(0, -1, 0, 2, 0, 8);
    total++; if (rlog.size() !== 2) begin bad++; $display("FAIL abort_rd_count got=%0d exp=2", rlog.size()); end
    for (int i = 0; i < 2; i++) begin
      total++;
      if (i >= rlog.size() || rlog[i] !== {8'(i + 5), 8'(i + 1)}) begin
        bad++; $display("FAIL abort_rd[%0d] got=%h exp=%h", i, (i < rlog.size()) ? rlog[i] : 16'h0, {8'(i + 5), 8'(i + 1)});
      end
    end
    total++; if (err_seen !== 1'b1) begin bad++; $display("FAIL abort_err_seen got=%b exp=1", err_seen); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL abort_done_count got=%0d exp=1", done_cnt); end
    total++; if (done_cyc - start_cyc !== 12) begin bad++; $display("FAIL abort_latency got=%0d exp=12", done_cyc - start_cyc); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy_after got=%b exp=0", busy); end
    repeat (3) @(posedge clk);
    #1;
    total++; if (err !== 1'b1) begin bad++; $display("FAIL abort_err_sticky got=%b exp=1", err); end
    start = 1;
    @(posedge clk); #1;
    start = 0;
    total++; if (err !== 1'b0) begin bad++; $display("FAIL abort_err_cleared got=%b exp=0", err); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL abort_restart_busy got=%b exp=1", busy); end
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic test_reset_mid_fill();
    run_job(0, -1, 0, -1, 0, 3);
    total++; if (wlog.size() !== 3) begin bad++; $display("FAIL rmf_pre_writes got=%0d exp=3", wlog.size()); end
    in_valid = 1;
    in_data = 8'h5A;
    rst = 1;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rmf_in_ready got=%b exp=0", in_ready); end
    total++; if (fifo_wren !== 2'b00) begin bad++; $display("FAIL rmf_wren got=%b exp=00", fifo_wren); end
    total++; if (fifo_wdata !== 8'h00) begin bad++; $display("FAIL rmf_wdata got=%h exp=00", fifo_wdata); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmf_busy got=%b exp=0", busy); end
    total++; if (fifo_rden !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL rmf_rden_ov_done got=%b%b%b exp=000", fifo_rden, out_valid, done);
    end
    @(posedge clk); #1;
    rst = 0;
    in_valid = 0;
    run_job(0, -1, 0, -1, 0, 8);
    for (int i = 0; i < 8; i++) begin
      total++;
      if (i >= wlog.size() || wlog[i] !== {(i < 4) ? 2'b01 : 2'b10, 8'(i + 1)}) begin
        bad++; $display("FAIL rmf_wr[%0d] got=%h exp=%h", i, (i < wlog.size()) ? wlog[i] : 10'h0, {(i < 4) ? 2'b01 : 2'b10, 8'(i + 1)});
      end
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (i >= rlog.size() || rlog[i] !== {8'(i + 5), 8'(i + 1)}) begin
        bad++; $display("FAIL rmf_rd[%0d] got=%h exp=%h", i, (i < rlog.size()) ? rlog[i] : 16'h0, {8'(i + 5), 8'(i + 1)});
      end
    end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL rmf_done_count got=%0d exp=1", done_cnt); end
    total++; if (done_cyc - start_cyc !== 13) begin bad++; $display("FAIL rmf_latency got=%0d exp=13", done_cyc - start_cyc); end
    total++; if (err_seen !== 1'b0) begin bad++; $display("FAIL rmf_err got=%b exp=0", err_seen); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_backpressure();
    test_start_busy();
    test_empty_abort();
    test_reset_mid_fill();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
